// File: rtl/seg_pkg.sv
// Shared constants and the active-low hex-to-segment table for the
// seven-segment display peripheral.
package seg_pkg;

    localparam logic [31:0] SEG_ADDR_DEF  = 32'hFFFF_F000;
    localparam logic [31:0] CTRL_ADDR_DEF = 32'hFFFF_F004;
    localparam int          SCAN_CNT_W    = 20;

    // Segment order {dp,g,f,e,d,c,b,a}, active-low; dp is always off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        logic [7:0] seg;
        case (nibble)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            4'hF:    seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble-to-segment decoder built on the package table.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    // Table lookup for the currently selected digit.
    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Memory-mapped 8-digit seven-segment display: data/mask registers on the
// CPU data bus, a programmable digit scan, and registered active-low drives.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter logic [31:0] SEG_ADDR  = SEG_ADDR_DEF,
    parameter logic [31:0] CTRL_ADDR = CTRL_ADDR_DEF,
    parameter int unsigned SCAN_DIV  = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_adr,
    input  logic [31:0] bus_wdin,
    input  logic        bus_we,
    output logic [31:0] bus_rd,
    output logic [7:0]  led_en,
    output logic [7:0]  led_seg
);

    localparam logic [SCAN_CNT_W-1:0] SCAN_LAST = SCAN_CNT_W'(SCAN_DIV - 1);

    logic [31:0]           data_reg_r;
    logic [7:0]            mask_reg_r;
    logic [SCAN_CNT_W-1:0] scan_cnt_r;
    logic [2:0]            digit_idx_r;
    logic [7:0]            led_en_r;
    logic [7:0]            led_seg_r;

    logic                  seg_wr_s;
    logic                  ctrl_wr_s;
    logic [3:0]            nibble_s;
    logic [7:0]            seg_s;
    logic [7:0]            en_next_s;

    assign seg_wr_s  = bus_we && (bus_adr == SEG_ADDR);
    assign ctrl_wr_s = bus_we && (bus_adr == CTRL_ADDR);
    assign nibble_s  = data_reg_r[{digit_idx_r, 2'b00} +: 4];

    seg_hex_decoder u_dec (
        .nibble (nibble_s),
        .seg    (seg_s)
    );

    // Readback mux; reflects register contents before any same-cycle write.
    always_comb begin
        bus_rd = 32'h0000_0000;
        if (bus_adr == SEG_ADDR) begin
            bus_rd = data_reg_r;
        end else if (bus_adr == CTRL_ADDR) begin
            bus_rd = {24'h00_0000, mask_reg_r};
        end else begin
            bus_rd = 32'h0000_0000;
        end
    end

    // Digit enable for the current slot; a masked digit stays dark for its slot.
    always_comb begin
        en_next_s = 8'hFF;
        if (mask_reg_r[digit_idx_r]) begin
            en_next_s = ~(8'h01 << digit_idx_r);
        end else begin
            en_next_s = 8'hFF;
        end
    end

    // CPU-writable data and mask registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg_r <= 32'h0000_0000;
            mask_reg_r <= 8'hFF;
        end else begin
            if (seg_wr_s) begin
                data_reg_r <= bus_wdin;
            end
            if (ctrl_wr_s) begin
                mask_reg_r <= bus_wdin[7:0];
            end
        end
    end

    // Scan divider; digit index wraps 7->0 naturally in 3 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_r  <= '0;
            digit_idx_r <= 3'd0;
        end else if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_r  <= '0;
            digit_idx_r <= digit_idx_r + 3'd1;
        end else begin
            scan_cnt_r  <= scan_cnt_r + SCAN_CNT_W'(1);
        end
    end

    // Output flops, one cycle behind the digit index and registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_en_r  <= 8'hFF;
            led_seg_r <= 8'hFF;
        end else begin
            led_en_r  <= en_next_s;
            led_seg_r <= seg_s;
        end
    end

    assign led_en  = led_en_r;
    assign led_seg = led_seg_r;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl with a 4-cycle scan divider.
module tb_seg_display_ctrl;

    localparam logic [31:0] SEG_A   = 32'hFFFF_F000;
    localparam logic [31:0] CTRL_A  = 32'hFFFF_F004;
    localparam logic [31:0] DECOY_A = 32'hFFFF_F008;
    localparam int          DIV     = 4;

    logic        clk;
    logic        rst;
    logic [31:0] bus_adr;
    logic [31:0] bus_wdin;
    logic        bus_we;
    logic [31:0] bus_rd;
    logic [7:0]  led_en;
    logic [7:0]  led_seg;

    typedef struct {
        int          id;
        logic [7:0]  en;
        logic [7:0]  seg;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   total_checks = 0;
    int   pass_checks  = 0;
    int   tick_no      = 0;

    // Hand-entered active-low hex glyphs {dp,g,f,e,d,c,b,a}.
    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference state: output flops, registers, edges since reset release.
    logic [7:0]  m_en   = 8'hFF;
    logic [7:0]  m_seg  = 8'hFF;
    logic [31:0] m_data = 32'h0;
    logic [7:0]  m_mask = 8'hFF;
    int          m_k    = 0;

    seg_display_ctrl #(
        .SEG_ADDR  (SEG_A),
        .CTRL_ADDR (CTRL_A),
        .SCAN_DIV  (DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus_adr  (bus_adr),
        .bus_wdin (bus_wdin),
        .bus_we   (bus_we),
        .bus_rd   (bus_rd),
        .led_en   (led_en),
        .led_seg  (led_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, queue what the DUT must show before the
    // coming edge, then advance the reference across that edge.
    task automatic tick(input logic r, input logic [31:0] adr,
                        input logic [31:0] wd, input logic we);
        exp_t e;
        int   d;
        rst = r; bus_adr = adr; bus_wdin = wd; bus_we = we;
        e.id  = tick_no;
        e.en  = m_en;
        e.seg = m_seg;
        if (adr == SEG_A)       e.rd = m_data;
        else if (adr == CTRL_A) e.rd = {24'h0, m_mask};
        else                    e.rd = 32'h0;
        exp_q.push_back(e);
        @(posedge clk);
        if (r) begin
            m_en = 8'hFF; m_seg = 8'hFF; m_data = 32'h0; m_mask = 8'hFF; m_k = 0;
        end else begin
            d     = (m_k / DIV) % 8;
            m_en  = m_mask[d] ? ~(8'h01 << d) : 8'hFF;
            m_seg = seg_tab[m_data[4*d +: 4]];
            if (we && adr == SEG_A)  m_data = wd;
            if (we && adr == CTRL_A) m_mask = wd[7:0];
            m_k++;
        end
        tick_no++;
        #1;
    endtask

    task automatic idle(input int n, input logic [31:0] adr);
        for (int i = 0; i < n; i++) tick(1'b0, adr, 32'h0, 1'b0);
    endtask

    // Monitor: compare every queued expectation at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total_checks++;
                if (led_en !== e.en)
                    $display("FAIL led_en @tick %0d: got %h expected %h", e.id, led_en, e.en);
                else pass_checks++;
                total_checks++;
                if (led_seg !== e.seg)
                    $display("FAIL led_seg @tick %0d: got %h expected %h", e.id, led_seg, e.seg);
                else pass_checks++;
                total_checks++;
                if (bus_rd !== e.rd)
                    $display("FAIL bus_rd @tick %0d: got %h expected %h", e.id, bus_rd, e.rd);
                else pass_checks++;
            end
        end
    end

    initial begin
        rst = 1'b1; bus_adr = SEG_A; bus_wdin = 32'h0; bus_we = 1'b0;
        @(posedge clk);
        #1;
        // Reset held: blanked outputs, reset register values on readback.
        tick(1'b1, SEG_A, 32'h0, 1'b0);
        tick(1'b1, CTRL_A, 32'h0, 1'b0);
        tick(1'b1, SEG_A, 32'h0, 1'b0);
        // Release: digit 0 with C0 one cycle later.
        idle(3, CTRL_A);
        // Full scan over digits 1..8 and wrap.
        tick(1'b0, SEG_A, 32'h8765_4321, 1'b1);
        idle(40, DECOY_A);
        // Hex letters plus readback, including the old-value-on-write cycle.
        tick(1'b0, SEG_A, 32'hFEDC_BA90, 1'b1);
        idle(36, SEG_A);
        // Digit mask 0x05.
        tick(1'b0, CTRL_A, 32'h0000_0005, 1'b1);
        idle(36, CTRL_A);
        // Decoy write must touch nothing.
        tick(1'b0, DECOY_A, 32'h1234_5678, 1'b1);
        idle(2, SEG_A);
        idle(2, CTRL_A);
        // Mid-slot write during digit 0.
        while ((m_k % (8 * DIV)) != 1) tick(1'b0, SEG_A, 32'h0, 1'b0);
        tick(1'b0, SEG_A, 32'h0000_000A, 1'b1);
        idle(8, SEG_A);
        // Reset in the middle of digit 5's slot.
        tick(1'b0, CTRL_A, 32'h0000_00FF, 1'b1);
        while (((m_k / DIV) % 8) != 5) tick(1'b0, SEG_A, 32'h0, 1'b0);
        tick(1'b0, SEG_A, 32'h0, 1'b0);
        tick(1'b1, SEG_A, 32'h0, 1'b0);
        idle(6, SEG_A);
        // Drain with a bound.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            total_checks++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
